bnn_pe_array: RTL and testbench
===============================

Name: bnn_pe_array

Overview:
- Binary-neural-network PE array for one output tile of O_CH channels.
- It consumes a fixed-length stream of 27-bit words on a single input bus. Each word is either a 3x3x3 binarized activation patch or a binarized weight kernel.
- For every channel it accumulates XNOR-popcount dot products over ROW_LENGTH*K activation patches.
- After the stream ends, it emits the O_CH signed partial sums serially, one per cycle, on psum_out.

Parameters:
- K, 10, number of passes; stream carries ROW_LENGTH*K activation patches.
- WIDTH, 14, psum_out width (two's complement).
- ROW_LENGTH, 11, PEs per row; patches per pass.
- O_CH, 8, number of PE rows, i.e. output channels.
- DATA_W, 27, word width (3x3x3 kernel bits).

Ports:
- clk_in, input, 1, clock; all state changes on its rising edge.
- rst_in, input, 1, asynchronous active-low reset.
- data_in, input, DATA_W, stream word; bit 1 = +1, bit 0 = -1.
- psum_out, output, WIDTH, serialized channel partial sum.

Behaviour:
- One clock; reset is asynchronous and active-low (clk_in, rst_in).
- While rst_in=0, all state clears: word counter = 0, all O_CH accumulators = 0, output sequencer idle, psum_out = 0.
- There is no valid strobe. The first rising edge with rst_in=1 samples stream word 0, and every following edge samples the next word.
- Total stream length N = (O_CH+1)*ROW_LENGTH*K words (990 at defaults).
- The stream is organised as ROW_LENGTH*K groups of O_CH+1 words:
  - group word 0 = activation patch A, held in an activation register;
  - group words 1..O_CH = weight kernels W[c] for channels c = 0..O_CH-1.
- Per weight word: contribution = 2*popcount(~(W[c] ^ A)) - 27, range -27..+27, added to accumulator c.
- The contribution uses the A of the same group, including when W[c] immediately follows A.
- Pipeline: the word sampled at edge t updates its accumulator at edge t+1 (one register stage, then popcount+add).
- Accumulator width is WIDTH, signed. At defaults the magnitude is at most 110*27 = 2970, so there is no overflow. For non-default parameters, overflow wraps modulo 2^WIDTH.
- Let E be the edge that samples word N-1.
- Output sequencing:
  - at edge E+2+j, psum_out <= accumulator j, for j = 0..O_CH-1;
  - from edge E+2+O_CH onward, psum_out holds the channel O_CH-1 value until reset.
- Before edge E+2, psum_out = 0.
- After word N-1, data_in is ignored and no further accumulation occurs until the next reset.
- Reset asserted mid-stream or mid-output aborts everything. After release, the stream restarts at word 0.
- X on data_in while rst_in=0 has no effect.

Decomposition:
- Shared package holds:
  - DATA_W;
  - the popcount offset constant 27;
  - the default O_CH, ROW_LENGTH, K, WIDTH;
  - the derived constant N and the counter widths (clog2 of O_CH+1 and of ROW_LENGTH*K).
- Natural sub-module: bnn_xnor_popcount. It is purely combinational: 27-bit A and W in, signed contribution out.
- Top level holds the group/word counters, activation register, accumulator bank, and output sequencer.

Test Plan:
- All-zero A and W for all 990 words, reset released before the first sample.
  Expected: psum_out = 14'h0B9A (2970) for ch0..ch7 on 8 consecutive cycles, first at edge E+2.
- Every W[c] = ~A, with A random per group.
  Expected: all 8 outputs = 14'h3466 (-2970).
- W[c] = A with the low c bits flipped.
  Expected: channel c = 110*(27-2c). Sequence is 2970, 2750, 2530, 2310, 2090, 1870, 1650, 1430.
- Even channels W = A, odd channels W = ~A.
  Expected: alternating 2970, -2970 (14'h3466), ...
  After ch7, psum_out holds 14'h3466 for 5 further cycles. psum_out = 0 throughout streaming.
- Assert rst_in for 1 cycle at word 500, then restart the full stream from the all-zero case.
  Expected: psum_out = 0 immediately on reset; final outputs again 2970 x8, with no residue from the aborted run.

Source files
------------

// File: rtl/bnn_pe_array_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pe_array_pkg
// Shared constants and types for the binarized PE array.
//   DATA_W      : width of one stream word (3x3x3 binarized kernel/patch)
//   POP_OFFSET  : offset that maps popcount 0..27 onto a signed -27..+27 score
//   DEF_*       : default array geometry and derived counter widths
// -----------------------------------------------------------------------------
package bnn_pe_array_pkg;

    localparam int DATA_W     = 27;
    localparam int POP_OFFSET = 27;
    localparam int POP_W      = $clog2(DATA_W + 1);  // popcount 0..27
    localparam int CONTRIB_W  = POP_W + 2;           // signed -27..+27

    localparam int DEF_O_CH       = 8;
    localparam int DEF_ROW_LENGTH = 11;
    localparam int DEF_K          = 10;
    localparam int DEF_WIDTH      = 14;

    localparam int DEF_N      = (DEF_O_CH + 1) * DEF_ROW_LENGTH * DEF_K;
    localparam int DEF_WIDX_W = $clog2(DEF_O_CH + 1);
    localparam int DEF_GRP_W  = $clog2(DEF_ROW_LENGTH * DEF_K);

    // clog2 that never returns 0, so degenerate geometries still get a 1-bit counter
    function automatic int clog2_min1(input int v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction

    // Stage-1 register contents: the sampled word plus what it is.
    typedef struct packed {
        logic              is_act;
        logic              is_wgt;
        logic              last;
        logic [DATA_W-1:0] word;
    } stage_t;

endpackage

// File: rtl/bnn_pe_array_xnor_popcount.sv
// -----------------------------------------------------------------------------
// bnn_xnor_popcount
// Combinational binarized dot product of one activation patch and one kernel.
//   a_i       : activation patch, bit 1 = +1, bit 0 = -1
//   w_i       : weight kernel, same encoding
//   contrib_o : 2*popcount(~(a^w)) - 27, signed, range -27..+27
// -----------------------------------------------------------------------------
module bnn_xnor_popcount
    import bnn_pe_array_pkg::*;
(
    input  logic        [DATA_W-1:0]    a_i,
    input  logic        [DATA_W-1:0]    w_i,
    output logic signed [CONTRIB_W-1:0] contrib_o
);

    logic [DATA_W-1:0]    match;
    logic [POP_W-1:0]     cnt;
    logic [CONTRIB_W-1:0] dbl;

    assign match = ~(a_i ^ w_i);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DATA_W; i++) begin
            cnt = cnt + POP_W'(match[i]);
        end
    end

    // Modular subtract in CONTRIB_W bits yields the two's complement score.
    assign dbl       = {1'b0, cnt, 1'b0};
    assign contrib_o = $signed(dbl - CONTRIB_W'(POP_OFFSET));

endmodule

// File: rtl/bnn_pe_array.sv
// -----------------------------------------------------------------------------
// bnn_pe_array
// Binarized PE array for one output tile of O_CH channels. Consumes a fixed
// stream of (O_CH+1)*ROW_LENGTH*K words, one per clock with no strobe: each
// group is an activation patch followed by O_CH weight kernels. Every weight
// adds its XNOR-popcount score against the group's patch into its channel
// accumulator. After the last word the O_CH sums leave serially on psum_out.
//   clk_in   : clock, rising edge
//   rst_in   : asynchronous active-low reset, restarts the stream at word 0
//   data_in  : stream word
//   psum_out : serialized signed partial sum, 0 until the first channel appears
// -----------------------------------------------------------------------------
module bnn_pe_array
    import bnn_pe_array_pkg::*;
#(
    parameter int K          = DEF_K,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ROW_LENGTH = DEF_ROW_LENGTH,
    parameter int O_CH       = DEF_O_CH
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [WIDTH-1:0]  psum_out
);

    localparam int GROUPS = ROW_LENGTH * K;
    localparam int WIDX_W = clog2_min1(O_CH + 1);
    localparam int GRP_W  = clog2_min1(GROUPS);
    localparam int IDX_W  = clog2_min1(O_CH);

    // Stream position: word within group, group index, and end-of-stream latch.
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [GRP_W-1:0]  grp_q,  grp_d;
    logic              done_q, done_d;

    // Stage 1: sampled word and its target channel.
    stage_t            stg_q,  stg_d;
    logic [IDX_W-1:0]  ch_q,   ch_d;

    // Stage 2: activation register and accumulator bank.
    logic [DATA_W-1:0] act_q;
    logic [WIDTH-1:0]  acc_q [O_CH];

    // Output sequencer.
    logic              out_act_q;
    logic [IDX_W-1:0]  out_idx_q;
    logic [WIDTH-1:0]  psum_q;

    logic signed [CONTRIB_W-1:0] contrib;
    logic [WIDTH-1:0]            contrib_ext;
    logic                        last_word;

    assign last_word = (widx_q == WIDX_W'(O_CH)) && (grp_q == GRP_W'(GROUPS - 1));

    always_comb begin
        widx_d = widx_q;
        grp_d  = grp_q;
        done_d = done_q;
        stg_d  = '0;
        ch_d   = ch_q;
        if (!done_q) begin
            stg_d.word   = data_in;
            stg_d.is_act = (widx_q == '0);
            stg_d.is_wgt = (widx_q != '0);
            stg_d.last   = last_word;
            ch_d         = IDX_W'(widx_q - WIDX_W'(1));
            if (widx_q == WIDX_W'(O_CH)) begin
                widx_d = '0;
                grp_d  = grp_q + GRP_W'(1);
            end else begin
                widx_d = widx_q + WIDX_W'(1);
            end
            done_d = last_word;
        end
    end

    // The patch is latched from stage 1, so a weight right behind its patch
    // reaches stage 2 one cycle after the patch landed in act_q: no bypass needed.
    bnn_xnor_popcount u_xnor_popcount (
        .a_i       (act_q),
        .w_i       (stg_q.word),
        .contrib_o (contrib)
    );

    assign contrib_ext = {{(WIDTH - CONTRIB_W){contrib[CONTRIB_W-1]}}, contrib};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            widx_q <= '0;
            grp_q  <= '0;
            done_q <= 1'b0;
            stg_q  <= '0;
            ch_q   <= '0;
        end else begin
            widx_q <= widx_d;
            grp_q  <= grp_d;
            done_q <= done_d;
            stg_q  <= stg_d;
            ch_q   <= ch_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            act_q <= '0;
            for (int c = 0; c < O_CH; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            if (stg_q.is_act) begin
                act_q <= stg_q.word;
            end
            // Wraps modulo 2^WIDTH on overflow.
            if (stg_q.is_wgt) begin
                acc_q[ch_q] <= acc_q[ch_q] + contrib_ext;
            end
        end
    end

    // The last word accumulates on the cycle stg_q.last is seen; the sequencer
    // arms on that same edge so channel 0 appears on the following one.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            out_act_q <= 1'b0;
            out_idx_q <= '0;
            psum_q    <= '0;
        end else if (stg_q.last) begin
            out_act_q <= 1'b1;
            out_idx_q <= '0;
        end else if (out_act_q) begin
            psum_q <= acc_q[out_idx_q];
            if (out_idx_q == IDX_W'(O_CH - 1)) begin
                out_act_q <= 1'b0;
            end else begin
                out_idx_q <= out_idx_q + IDX_W'(1);
            end
        end
    end

    assign psum_out = psum_q;

endmodule

// File: tb/tb_bnn_pe_array.sv
// -----------------------------------------------------------------------------
// tb_bnn_pe_array
// Self-checking bench for bnn_pe_array at default parameters. Streams are
// generated per scenario, expected channel sums come from a direct dot-product
// model over the stored stream, and psum_out is sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_bnn_pe_array;

    localparam int DW     = 27;
    localparam int O_CH   = 8;
    localparam int GROUPS = 11 * 10;
    localparam int N      = (O_CH + 1) * GROUPS;
    localparam int W      = 14;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [W-1:0]  psum_out;

    always #5 clk_in = ~clk_in;

    bnn_pe_array dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .data_in  (data_in),
        .psum_out (psum_out)
    );

    logic [DW-1:0] stream [N];
    logic [W-1:0]  exp_v  [O_CH];
    int checks = 0;
    int errors = 0;

    // mode 0: all zero, 1: W=~A, 2: A with low c bits flipped,
    // 3: even W=A odd W=~A, 4: fully random
    task automatic build(input int mode);
        logic [DW-1:0] a, w, mask;
        for (int g = 0; g < GROUPS; g++) begin
            a = (mode == 0) ? '0 : DW'($urandom);
            stream[g*(O_CH+1)] = a;
            for (int c = 0; c < O_CH; c++) begin
                mask = (DW'(1) << c) - DW'(1);
                case (mode)
                    0:       w = '0;
                    1:       w = ~a;
                    2:       w = a ^ mask;
                    3:       w = (c % 2 == 1) ? ~a : a;
                    default: w = DW'($urandom);
                endcase
                stream[g*(O_CH+1) + 1 + c] = w;
            end
        end
        // Reference: sum of +1/-1 products over every (patch, kernel) pair.
        for (int c = 0; c < O_CH; c++) begin
            int s = 0;
            for (int g = 0; g < GROUPS; g++) begin
                logic [DW-1:0] aa, ww;
                aa = stream[g*(O_CH+1)];
                ww = stream[g*(O_CH+1) + 1 + c];
                for (int b = 0; b < DW; b++) s += (aa[b] == ww[b]) ? 1 : -1;
            end
            exp_v[c] = W'(s);
        end
    endtask

    // Enters at a falling edge with rst_in low; releases reset and streams.
    // abort_at >= 0 pulls reset low right after word abort_at-1 was sampled.
    task automatic stream_and_check(input string name, input int abort_at);
        int nz = 0;
        rst_in  = 1'b1;
        data_in = stream[0];
        for (int i = 1; i < N; i++) begin
            @(negedge clk_in);
            if (psum_out !== '0) nz++;
            if (i == abort_at) begin
                rst_in  = 1'b0;
                data_in = DW'($urandom);
                #1;
                checks++;
                if (nz != 0 || psum_out !== '0) begin
                    errors++;
                    $display("FAIL %s_abort: nonzero samples %0d, psum_out %h, expected 0", name, nz, psum_out);
                end
                return;
            end
            data_in = stream[i];
        end
        @(negedge clk_in);  // after edge E: input now ignored
        data_in = DW'($urandom);
        if (psum_out !== '0) nz++;
        @(negedge clk_in);  // after edge E+1
        if (psum_out !== '0) nz++;
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL %s_zero_before_output: %0d nonzero samples, expected 0", name, nz);
        end
        for (int j = 0; j < O_CH; j++) begin
            @(negedge clk_in);
            data_in = DW'($urandom);
            checks++;
            if (psum_out !== exp_v[j]) begin
                errors++;
                $display("FAIL %s_ch%0d: got %h expected %h", name, j, psum_out, exp_v[j]);
            end
        end
        for (int h = 0; h < 5; h++) begin
            @(negedge clk_in);
            data_in = DW'($urandom);
            checks++;
            if (psum_out !== exp_v[O_CH-1]) begin
                errors++;
                $display("FAIL %s_hold%0d: got %h expected %h", name, h, psum_out, exp_v[O_CH-1]);
            end
        end
    endtask

    // Asserts reset while outputs are live; leaves at a falling edge, rst_in low.
    task automatic do_reset(input string name);
        @(negedge clk_in);
        rst_in  = 1'b0;
        data_in = DW'($urandom);
        #1;
        checks++;
        if (psum_out !== '0) begin
            errors++;
            $display("FAIL %s_reset_clear: got %h expected 0", name, psum_out);
        end
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            data_in = DW'($urandom);
        end
        checks++;
        if (psum_out !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", psum_out);
        end
    endtask

    task automatic test_all_zero();
        build(0);
        stream_and_check("all_zero", -1);
        do_reset("all_zero");
    endtask

    task automatic test_inverse();
        build(1);
        stream_and_check("inverse", -1);
        do_reset("inverse");
    endtask

    task automatic test_bitflip();
        build(2);
        stream_and_check("bitflip", -1);
        do_reset("bitflip");
    endtask

    task automatic test_alternating();
        build(3);
        stream_and_check("alternating", -1);
        do_reset("alternating");
    endtask

    task automatic test_random();
        build(4);
        stream_and_check("random", -1);
        do_reset("random");
    endtask

    task automatic test_mid_reset();
        build(4);
        stream_and_check("mid_reset", 500);
        @(negedge clk_in);
        build(0);
        stream_and_check("after_abort", -1);
        do_reset("after_abort");
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_inverse();
        test_bitflip();
        test_alternating();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
